// File: rtl/fetch_unit.sv
// Purpose: MIPS instruction-fetch stage; owns the PC, fetches from the instruction SRAM, fills IF/ID.
// Latency: data acked at edge N appears on instr_d/pc_d after edge N; 1 instr/cycle with zero-wait memory.
// Backpressure: stall_d freezes IF/ID; a one-entry skid absorbs the in-flight fetch, no new fetch until release.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   inst_req/inst_addr/inst_ack   single-outstanding fetch handshake; inst_rdata valid in the ack cycle
//   stall_d                       decode stall; IF/ID holds
//   redirect/redirect_pc          ID-resolved taken branch/jump (delay slot still executes)
//   flush/flush_pc                exception restart, highest non-reset priority
//   instr_d/pc_d/pc_plus8_d/valid_d  IF/ID pipeline register outputs
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  input  logic        stall_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus8_d,
  output logic        valid_d
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] instr_nx, pcd_nx;
  logic        valid_nx;
  logic [31:0] skid_instr, skid_instr_nx;
  logic [31:0] skid_pc, skid_pc_nx;
  logic        pend_valid, pend_valid_nx;
  logic [31:0] pend_pc, pend_pc_nx;
  logic        redir_ok;
  logic [31:0] seq_pc;

  assign redir_ok   = redirect & ~stall_d;
  // A redirect deferred while its delay slot was still in flight takes effect at the next ack.
  assign seq_pc     = pend_valid ? pend_pc : pc + 32'd4;

  assign inst_req   = (state == REQ) || (state == DROP);
  assign inst_addr  = pc;
  assign pc_plus8_d = pc_d + 32'd8;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      instr_d    <= 32'h0;
      pc_d       <= 32'h0;
      valid_d    <= 1'b0;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
      pend_valid <= 1'b0;
      pend_pc    <= 32'h0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      instr_d    <= instr_nx;
      pc_d       <= pcd_nx;
      valid_d    <= valid_nx;
      skid_instr <= skid_instr_nx;
      skid_pc    <= skid_pc_nx;
      pend_valid <= pend_valid_nx;
      pend_pc    <= pend_pc_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    instr_nx      = instr_d;
    pcd_nx        = pc_d;
    valid_nx      = valid_d;
    skid_instr_nx = skid_instr;
    skid_pc_nx    = skid_pc;
    pend_valid_nx = pend_valid;
    pend_pc_nx    = pend_pc;

    case (state)
      IDLE: begin
        state_nx = REQ;
        if (flush) pc_nx = flush_pc;
      end

      REQ: begin
        if (flush) begin
          valid_nx = 1'b0;
          if (inst_ack) begin
            pc_nx         = flush_pc;
            pend_valid_nx = 1'b0;
          end else begin
            // The outstanding address must stay on the bus until acked, so pc is
            // left alone and the restart target parks in pend_pc (overwriting any
            // deferred redirect, which the flush cancels).
            pend_valid_nx = 1'b1;
            pend_pc_nx    = flush_pc;
            state_nx      = DROP;
          end
        end else if (inst_ack) begin
          pend_valid_nx = 1'b0;
          // With an ack in the redirect cycle, the acked word is the delay slot.
          pc_nx = redir_ok ? redirect_pc : seq_pc;
          if (stall_d) begin
            skid_instr_nx = inst_rdata;
            skid_pc_nx    = pc;
            state_nx      = HOLD;
          end else begin
            instr_nx = inst_rdata;
            pcd_nx   = pc;
            valid_nx = 1'b1;
          end
        end else if (!stall_d) begin
          valid_nx = 1'b0;
          // Delay slot not yet back: remember the target, apply it at the ack.
          if (redirect) begin
            pend_valid_nx = 1'b1;
            pend_pc_nx    = redirect_pc;
          end
        end
      end

      HOLD: begin
        if (flush) begin
          valid_nx      = 1'b0;
          pend_valid_nx = 1'b0;
          pc_nx         = flush_pc;
          state_nx      = REQ;
        end else if (!stall_d) begin
          instr_nx = skid_instr;
          pcd_nx   = skid_pc;
          valid_nx = 1'b1;
          // The delay slot is the skid entry; pc already points past it.
          if (redirect) pc_nx = redirect_pc;
          state_nx = REQ;
        end
      end

      DROP: begin
        valid_nx = 1'b0;
        if (inst_ack) begin
          pc_nx         = flush ? flush_pc : pend_pc;
          pend_valid_nx = 1'b0;
          state_nx      = REQ;
        end else if (flush) begin
          pend_pc_nx = flush_pc;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS pipeline, directly upstream of the decode stage that holds the main decoder. Owns the PC, issues one-outstanding-request fetches to the instruction SRAM port, and fills the IF/ID pipeline register. It has a one-entry skid buffer for decode stalls. It accepts branch/jump redirects resolved in ID and honours the MIPS branch delay slot. It accepts exception flushes.

## Interface
- RESET_PC, 32'hBFC0_0000, PC of the first fetch after reset.
- clk  in  1  pipeline clock, all state updates on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- inst_req  out  1  fetch request; inst_addr held stable while high.
- inst_addr  out  32  fetch address (word aligned).
- inst_ack  in  1  fetch completes at the edge where inst_req & inst_ack.
- inst_rdata  in  32  instruction, valid in the ack cycle.
- stall_d  in  1  ID stalled; IF/ID register must hold.
- redirect  in  1  ID-resolved taken branch/jump/jr/jal; ignored when stall_d=1.
- redirect_pc  in  32  target for redirect.
- flush  in  1  exception flush; highest non-reset priority.
- flush_pc  in  32  restart PC for flush.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pc_plus8_d  out  32  pc_d+8, link address for jal/jalr/bgezal/bltzal.
- valid_d  out  1  IF/ID contents are a real instruction.

## Operation
- Registers: pc (address of the current/next fetch), IF/ID {instr, pc, valid}, skid {instr, pc}, pend_valid/pend_pc (deferred redirect).
- States: IDLE, REQ, HOLD, DROP. inst_req=1 in REQ and DROP, else 0; inst_addr=pc.
- IDLE: the only state during reset. Goes to REQ on the first edge after reset release.
- REQ, ack and !stall_d: IF/ID <= {inst_rdata, pc, 1}; pc <= next_pc; stay REQ.
- REQ, ack and stall_d: skid <= {inst_rdata, pc}; pc <= next_pc; go HOLD.
- REQ, no ack and !stall_d: valid_d <= 0 (bubble).
- HOLD: when stall_d falls, IF/ID <= skid with valid=1, then go REQ.
- next_pc selection at an ack: if pend_valid, next_pc = pend_pc and pend_valid is cleared; else pc+4.
- Redirect (redirect & !stall_d), delay-slot rule. The branch sits in ID, and its delay slot is the fetch at pc_d+4. The delay slot always executes.
  - REQ, no ack this cycle (delay slot still outstanding): pend_valid <= 1, pend_pc <= redirect_pc.
  - REQ with ack this cycle: the acked instruction is the delay slot; pc <= redirect_pc.
  - HOLD being released (delay slot in skid): pc <= redirect_pc.
- Flush: valid_d <= 0, and pend_valid and the skid are discarded. pc <= flush_pc.
  - If a request is outstanding without ack, go DROP: hold req/addr until ack, discard the data, then REQ at flush_pc.
  - Flush with ack in the same cycle discards the data and goes to REQ.
  - Flush in HOLD goes to REQ.
- Priority: rst > flush > redirect > sequential. Flush also overrides stall_d for IF/ID valid.
- pc arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. No alignment check (address errors are detected downstream).

## Timing
- Reset values: inst_req=0, inst_addr=RESET_PC, instr_d=0, pc_d=0, pc_plus8_d=8, valid_d=0, pend_valid=0.
- First inst_req=1 in the first cycle after rst deasserts, with inst_addr=RESET_PC.
- Latency: data acked at edge N appears on instr_d/pc_d after edge N.
- Zero-wait memory (ack whenever req) sustains 1 instruction per cycle.
- At most one outstanding request; inst_addr never changes while inst_req=1 and no ack.
- stall_d=1 freezes instr_d/pc_d/valid_d exactly. The skid absorbs at most one instruction; no fetch is issued in HOLD.
- Asynchronous rst mid-request abandons the request immediately (inst_req drops without ack); memory must tolerate this.

## Test plan
- Reset and stream, ack every cycle: fetches at BFC00000, BFC00004, BFC00008; pc_d follows one cycle after each; valid_d=1 continuously; pc_plus8_d=pc_d+8.
- Two-wait-state ack: inst_req stays high for 3 cycles with constant addr; valid_d=0 for 2 cycles, then 1.
- Stall at ack: stall_d=1 for 3 cycles at the ack of BFC00008. Required: IF/ID frozen, inst_req=0 in HOLD; on release pc_d=BFC00008, then a fetch at BFC0000C.
- Redirect, delay slot still outstanding: branch at BFC00010 redirects to 80001000 while the BFC00014 fetch is waiting. Required: BFC00014 is delivered, the next fetch is 80001000, and BFC00018 is never requested.
- Redirect with simultaneous ack: same as above with ack in the redirect cycle. Required: next inst_addr=80001000.
- Flush during outstanding request (flush_pc=BFC00380): the request is held until ack and its data dropped (valid_d=0). The next fetch is BFC00380. A pending redirect is cancelled.
